// File: rtl/gate_test_sequencer.sv
// Self-test sequencer for two-input gate cells: sweeps {ta,tb} = 00..11, waits a settle time,
// samples ty against a truth table and reports a fail map, error count and pass flag.
module gate_test_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [3:0]  TRUTH         = 4'b1000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       pass_o,
  output logic       ta_o,
  output logic       tb_o,
  input  logic       ty_i,
  output logic [3:0] fail_vec_o,
  output logic [2:0] err_cnt_o
);

  localparam logic [7:0] SettleCnt = 8'(SETTLE_CYCLES);

  typedef enum logic [2:0] {StIdle, StApply, StSettle, StCheck, StDone} state_e;

  state_e     state_q;
  logic [7:0] cnt_q;
  logic [1:0] idx_q;
  logic       busy_q, done_q, pass_q, ta_q, tb_q;
  logic [3:0] fail_vec_q;
  logic [2:0] err_cnt_q;

  logic       mismatch;
  logic [2:0] err_cnt_d;

  always_comb begin
    mismatch  = ty_i != TRUTH[idx_q];
    err_cnt_d = err_cnt_q + {2'b00, mismatch};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      cnt_q      <= 8'd0;
      idx_q      <= 2'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      ta_q       <= 1'b0;
      tb_q       <= 1'b0;
      fail_vec_q <= 4'b0000;
      err_cnt_q  <= 3'd0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          ta_q <= 1'b0;
          tb_q <= 1'b0;
          if (start_i) begin
            fail_vec_q <= 4'b0000;
            err_cnt_q  <= 3'd0;
            pass_q     <= 1'b0;
            idx_q      <= 2'd0;
            busy_q     <= 1'b1;
            state_q    <= StApply;
          end
        end
        StApply: begin
          // Vector lands on ta/tb at the end of APPLY, so ty has SETTLE_CYCLES+1 cycles to settle
          {ta_q, tb_q} <= idx_q;
          cnt_q        <= SettleCnt;
          state_q      <= (SETTLE_CYCLES == 0) ? StCheck : StSettle;
        end
        StSettle: begin
          cnt_q <= cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
            state_q <= StCheck;
          end
        end
        StCheck: begin
          if (mismatch) begin
            fail_vec_q[idx_q] <= 1'b1;
            err_cnt_q         <= err_cnt_d;
          end
          if (idx_q == 2'd3) begin
            done_q  <= 1'b1;
            pass_q  <= (err_cnt_d == 3'd0);
            state_q <= StDone;
          end else begin
            idx_q   <= idx_q + 2'd1;
            state_q <= StApply;
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          ta_q    <= 1'b0;
          tb_q    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign pass_o     = pass_q;
  assign ta_o       = ta_q;
  assign tb_o       = tb_q;
  assign fail_vec_o = fail_vec_q;
  assign err_cnt_o  = err_cnt_q;

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Bench for gate_test_sequencer: three instances with different settle/truth settings, driven by
// a shared start/rst and a selectable gate cell, checked each cycle against a sweep-timeline model.
module tb_gate_test_sequencer;

  localparam int unsigned S0 = 2;
  localparam int unsigned S1 = 0;
  localparam int unsigned S2 = 3;
  localparam logic [3:0]  T0 = 4'b1000;
  localparam logic [3:0]  T1 = 4'b1000;
  localparam logic [3:0]  T2 = 4'b1110;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  int         g = 0;      // gate cell: 0 AND, 1 stuck-0, 2 NAND, 3 OR, 4 stuck-1, 5 XOR
  logic       dly = 1'b0; // gate output lags its inputs by one cycle

  logic       busy[3], done[3], pass[3], ta[3], tb[3], ty[3];
  logic [3:0] fail_vec[3];
  logic [2:0] err_cnt[3];
  logic [2:0] ty_dly;

  int         sets[3];
  logic [3:0] truths[3];

  // Model state
  logic       m_run[3];
  int         m_p[3];
  logic [3:0] m_fail[3];
  logic       m_pass[3];
  logic [1:0] m_vec[3];
  logic       m_dly[3];
  logic       e_busy[3], e_done[3];

  int  cyc = 0;
  int  n_cmp = 0;
  int  n_bad = 0;
  bit  chk_en = 1'b0;
  int  done_cnt[3];
  int  last_done[3];
  int  prev_done[3];

  always #5 clk = ~clk;

  gate_test_sequencer #(.SETTLE_CYCLES(S0), .TRUTH(T0)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .busy_o(busy[0]), .done_o(done[0]),
    .pass_o(pass[0]), .ta_o(ta[0]), .tb_o(tb[0]), .ty_i(ty[0]), .fail_vec_o(fail_vec[0]),
    .err_cnt_o(err_cnt[0])
  );
  gate_test_sequencer #(.SETTLE_CYCLES(S1), .TRUTH(T1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .busy_o(busy[1]), .done_o(done[1]),
    .pass_o(pass[1]), .ta_o(ta[1]), .tb_o(tb[1]), .ty_i(ty[1]), .fail_vec_o(fail_vec[1]),
    .err_cnt_o(err_cnt[1])
  );
  gate_test_sequencer #(.SETTLE_CYCLES(S2), .TRUTH(T2)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .busy_o(busy[2]), .done_o(done[2]),
    .pass_o(pass[2]), .ta_o(ta[2]), .tb_o(tb[2]), .ty_i(ty[2]), .fail_vec_o(fail_vec[2]),
    .err_cnt_o(err_cnt[2])
  );

  function automatic logic gate(input int gm, input logic [1:0] v);
    case (gm)
      0:       return v == 2'b11;
      1:       return 1'b0;
      2:       return v != 2'b11;
      3:       return v != 2'b00;
      4:       return 1'b1;
      default: return ^v;
    endcase
  endfunction

  // Gate cells under test
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) ty_dly[i] <= gate(g, {ta[i], tb[i]});
  end
  assign ty[0] = dly ? ty_dly[0] : gate(g, {ta[0], tb[0]});
  assign ty[1] = dly ? ty_dly[1] : gate(g, {ta[1], tb[1]});
  assign ty[2] = dly ? ty_dly[2] : gate(g, {ta[2], tb[2]});

  task automatic check(input string name, input int i, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s[%0d] @edge %0d: got %0h required %0h", name, i, cyc, act, exp);
    end
  endtask

  // Sweep timeline: phase p counts cycles since the accepting edge; vector k owns p in
  // [k*per, (k+1)*per), its last cycle is the check, p == 4*per is the done cycle.
  task automatic model_step(input int i);
    int per, len, k, off;
    logic tym;
    per = sets[i] + 2;
    len = 4 * per;
    tym = dly ? m_dly[i] : gate(g, m_vec[i]);
    m_dly[i] = gate(g, m_vec[i]);
    if (rst) begin
      m_run[i] = 1'b0; m_p[i] = 0; m_fail[i] = 4'b0000; m_pass[i] = 1'b0;
    end else if (m_run[i]) begin
      if (m_p[i] < len) begin
        k = m_p[i] / per; off = m_p[i] % per;
        if (off == per - 1 && tym != truths[i][k]) m_fail[i][k] = 1'b1;
      end
      if (m_p[i] == len - 1) m_pass[i] = (m_fail[i] == 4'b0000);
      if (m_p[i] == len) m_run[i] = 1'b0;
      else m_p[i]++;
    end else if (start) begin
      m_run[i] = 1'b1; m_p[i] = 0; m_fail[i] = 4'b0000; m_pass[i] = 1'b0;
    end
    if (m_run[i]) begin
      k = m_p[i] / per; off = m_p[i] % per;
      e_busy[i] = 1'b1;
      e_done[i] = (m_p[i] == len);
      if (m_p[i] == len) m_vec[i] = 2'd3;
      else if (off == 0) m_vec[i] = (k == 0) ? 2'd0 : 2'(k - 1);
      else m_vec[i] = 2'(k);
    end else begin
      e_busy[i] = 1'b0; e_done[i] = 1'b0; m_vec[i] = 2'd0;
    end
  endtask

  initial begin
    sets = '{int'(S0), int'(S1), int'(S2)};
    truths = '{T0, T1, T2};
    for (int i = 0; i < 3; i++) begin
      m_run[i] = 1'b0; m_p[i] = 0; m_fail[i] = 4'b0000; m_pass[i] = 1'b0;
      m_vec[i] = 2'd0; m_dly[i] = 1'b0; e_busy[i] = 1'b0; e_done[i] = 1'b0;
      done_cnt[i] = 0; last_done[i] = 0; prev_done[i] = 0;
    end
    forever begin
      @(posedge clk);
      cyc++;
      for (int i = 0; i < 3; i++) model_step(i);
    end
  end

  // Compare process
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
        if (chk_en) begin
          check("busy", i, 32'(busy[i]), 32'(e_busy[i]));
          check("done", i, 32'(done[i]), 32'(e_done[i]));
          check("pass", i, 32'(pass[i]), 32'(m_pass[i]));
          check("ta_tb", i, 32'({ta[i], tb[i]}), 32'(m_vec[i]));
          check("fail_vec", i, 32'(fail_vec[i]), 32'(m_fail[i]));
          check("err_cnt", i, 32'(err_cnt[i]), 32'($countones(m_fail[i])));
        end
        if (done[i] === 1'b1) begin
          prev_done[i] = last_done[i];
          last_done[i] = cyc;
          done_cnt[i]++;
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_all(input int b0, input int b1, input int b2, input int budget);
    int n = 0;
    while ((done_cnt[0] <= b0 || done_cnt[1] <= b1 || done_cnt[2] <= b2) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("sweep_timeout", 0, 32'(n < budget), 32'd1);
  endtask

  // Directed sweep with hand-computed fail maps per instance; lat = expected edges E0 -> done
  task automatic sweep(input int gm, input logic dl, input logic [3:0] f0, input logic [3:0] f1,
                       input logic [3:0] f2);
    int b[3];
    int e0;
    logic [3:0] f[3];
    int lat[3];
    f = '{f0, f1, f2};
    lat = '{16, 8, 20};
    do_reset();
    g = gm; dly = dl;
    for (int i = 0; i < 3; i++) b[i] = done_cnt[i];
    start = 1'b1;
    e0 = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    wait_all(b[0], b[1], b[2], 40);
    for (int i = 0; i < 3; i++) begin
      check("lit_fail_vec", i, 32'(fail_vec[i]), 32'(f[i]));
      check("lit_err_cnt", i, 32'(err_cnt[i]), 32'($countones(f[i])));
      check("lit_pass", i, 32'(pass[i]), 32'(f[i] == 4'b0000));
      check("lit_done_latency", i, 32'(last_done[i] - e0), 32'(lat[i]));
    end
  endtask

  initial begin
    int b0;
    int hold;
    // Reset held with start high: nothing may start
    @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("rst_busy", i, 32'(busy[i]), 32'd0);
      check("rst_outs", i, 32'({done[i], pass[i], ta[i], tb[i], fail_vec[i], err_cnt[i]}), 32'd0);
    end

    sweep(0, 1'b0, 4'b0000, 4'b0000, 4'b0110); // good AND
    sweep(1, 1'b0, 4'b1000, 4'b1000, 4'b1110); // stuck-at-0
    sweep(2, 1'b0, 4'b1111, 4'b1111, 4'b1001); // NAND cell
    sweep(0, 1'b1, 4'b0000, 4'b1000, 4'b0110); // slow AND cell

    // Reset during vector 2 of instance 0: sweep abandoned, no done
    do_reset();
    g = 0; dly = 1'b0;
    b0 = done_cnt[0];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", 0, 32'(busy[0]), 32'd0);
    check("midrst_fail_vec", 0, 32'(fail_vec[0]), 32'd0);
    repeat (20) @(negedge clk);
    check("midrst_no_done", 0, 32'(done_cnt[0]), 32'(b0));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_all(done_cnt[0], done_cnt[1], done_cnt[2], 40);
    check("after_rst_pass", 0, 32'(pass[0]), 32'd1);

    // Starts during SETTLE of vector 1 and in the DONE cycle are ignored
    do_reset();
    b0 = done_cnt[0];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hold = 0;
    while (done[0] !== 1'b1 && hold < 30) begin @(negedge clk); hold++; end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (25) @(negedge clk);
    check("ignored_starts_done_cnt", 0, 32'(done_cnt[0] - b0), 32'd1);
    check("ignored_starts_idle", 0, 32'(busy[0]), 32'd0);

    // Held start: back-to-back sweeps with one IDLE cycle between
    do_reset();
    start = 1'b1;
    repeat (50) @(negedge clk);
    check("held_spacing", 0, 32'(last_done[0] - prev_done[0]), 32'd18);
    check("held_spacing", 1, 32'(last_done[1] - prev_done[1]), 32'd10);
    check("held_spacing", 2, 32'(last_done[2] - prev_done[2]), 32'd22);
    start = 1'b0;

    // Randomised traffic against the model
    hold = 0;
    repeat (3000) begin
      @(negedge clk);
      rst = ($urandom_range(0, 199) == 0);
      if (hold > 0) begin
        start = 1'b1;
        hold--;
      end else begin
        start = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 99) == 0) hold = $urandom_range(20, 80);
      end
      if ($urandom_range(0, 29) == 0) g = $urandom_range(0, 5);
      if ($urandom_range(0, 49) == 0) dly = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gate_test_sequencer.md
# gate_test_sequencer

Self-test controller for the two-input primitive gate cells (and_gate and siblings). It drives every input combination into one gate under test and waits a programmable settle time. It then samples the gate output, compares it against a parameterised truth table and reports a per-vector fail map, an error count and a pass flag. It sits between a bench or BIST host (start/done handshake) and the gate cell (ta/tb/ty).

## Interface
Parameters:
- SETTLE_CYCLES, default 2: cycles between applying a vector and sampling ty (0..255).
- TRUTH, default 4'b1000: expected ty per vector index; bit i = expected output for {ta,tb}=i (AND=4'b1000, OR=4'b1110, NAND=4'b0111).

Ports:
- clk  input  1  one clock; all state updates on rising edge.
- rst  input  1  reset is synchronous and active-high.
- start  input  1  request a sweep; sampled only in IDLE.
- busy  output  1  high from the cycle after start is accepted through the DONE cycle.
- done  output  1  one-cycle pulse at end of sweep.
- pass  output  1  1 if sweep had zero mismatches; valid from done, held until next accepted start.
- ta  output  1  gate input a (vector index bit 1).
- tb  output  1  gate input b (vector index bit 0).
- ty  input  1  gate output under test (combinational from ta/tb).
- fail_vec  output  4  bit i set if vector i mismatched; held until next accepted start.
- err_cnt  output  3  number of mismatching vectors, 0..4; held until next accepted start.

## Operation
- States: IDLE, APPLY, SETTLE, CHECK, DONE. 8-bit settle counter, 2-bit vector index idx.
- Reset: state=IDLE. busy=0, done=0, pass=0, ta=0, tb=0, fail_vec=0, err_cnt=0, idx=0.
- IDLE: ta=tb=0. If start=1: clear fail_vec, err_cnt, pass; set idx=0; go APPLY.
- APPLY (1 cycle): register {ta,tb}=idx; load settle counter with SETTLE_CYCLES. Next state is SETTLE, or CHECK if SETTLE_CYCLES=0.
- SETTLE: decrement the counter each cycle; go CHECK when it reaches 1, so SETTLE lasts exactly SETTLE_CYCLES cycles.
- CHECK (1 cycle): compare ty with TRUTH[idx]. On mismatch, set fail_vec[idx] and increment err_cnt.
  - If idx=3, go DONE.
  - Otherwise increment idx and go APPLY.
- DONE (1 cycle): done=1. pass is set to 1 iff err_cnt=0, including any mismatch found in the final CHECK. Next state IDLE.
- ta/tb stay constant from APPLY through CHECK of the same vector. They change only on entry to the next APPLY or to IDLE.
- Vector order is fixed: 00, 01, 10, 11 ({ta,tb}).
- err_cnt saturates naturally at 4 (max one per vector); 3 bits suffice and cannot wrap.

## Timing
- Let E0 be the edge that samples start=1 in IDLE; busy is high from E0.
- Each vector takes SETTLE_CYCLES+2 cycles: APPLY + SETTLE + CHECK.
- ty is sampled at the edge ending CHECK, which is SETTLE_CYCLES+1 cycles after ta/tb change.
- done is high in the cycle following edge E0+4*(SETTLE_CYCLES+2). Default: done is high after E0+16 edges.
- pass, fail_vec and err_cnt are final in the done cycle and stable until the next accepted start.
- Back to IDLE one edge after done. start is accepted at the earliest in that IDLE cycle; a new sweep restarts at most 1 cycle after DONE.
- start while busy, including in the DONE cycle: ignored, with no effect on the current sweep.
- start held continuously: sweeps repeat with exactly one IDLE cycle between them.
- rst mid-sweep: on the next edge all outputs take their reset values and state=IDLE. A partial fail_vec is discarded and no done is produced.
- rst and start asserted together: rst wins, and start is not accepted.

## Test plan
- Reset: assert rst 2 cycles with start=1 -> busy=0, done=0, pass=0, ta=tb=0, fail_vec=0, err_cnt=0; no sweep starts.
- Good AND cell, defaults: pulse start at E0 -> {ta,tb} steps 00, 01, 10, 11, each held 4 cycles; done single pulse after E0+16; pass=1, err_cnt=0, fail_vec=4'b0000.
- Stuck-at-0 DUT (ty=0), TRUTH=4'b1000 -> fail_vec=4'b1000, err_cnt=1, pass=0. Swapping in a NAND cell -> fail_vec=4'b1111, err_cnt=4, pass=0.
- SETTLE_CYCLES=0: start at E0 -> each vector 2 cycles, done after E0+8. Slow DUT with ty delayed 1 cycle -> vectors whose output changes relative to the previous vector are flagged. Against the AND truth table that is only vector 3: fail_vec=4'b1000, err_cnt=1.
- Reset mid-run: assert rst while idx=2 -> next cycle all outputs at reset values, no done pulse. A following start runs a full 4-vector sweep with pass=1.
- Protocol: pulse start during SETTLE of vector 1 and again in the DONE cycle -> both ignored, exactly one done. Then hold start high -> second sweep begins 1 cycle after DONE, and done pulses are spaced 4*(SETTLE_CYCLES+2)+2 cycles apart.
